// File: rtl/comparator_operand_serializer.sv
// Transmit side of the serial comparator link: buffers one operand pair and shifts
// operand pairs out MSB-first, one bit pair per beat, with backpressure and early abort.
module comparator_operand_serializer #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a_in,
    input  logic [N-1:0]  b_in,
    output logic          ser_valid,
    input  logic          ser_ready,
    output logic          ser_a,
    output logic          ser_b,
    output logic          ser_first,
    output logic          ser_last,
    input  logic          abort,
    output logic          word_done,
    output logic          word_aborted,
    output logic          busy,
    output logic [CW-1:0] done_count
);

    localparam int unsigned CNTW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTW-1:0] CNT_TOP = CNTW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sa_q, sa_d;
    logic [N-1:0]    sb_q, sb_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    pa_q, pa_d;
    logic [N-1:0]    pb_q, pb_d;
    logic            pv_q, pv_d;
    logic            word_done_q, word_done_d;
    logic            word_aborted_q, word_aborted_d;
    logic [CW-1:0]   done_count_q, done_count_d;

    logic handshake;
    logic beat;
    logic cnt_zero;
    logic word_end;

    assign in_ready  = ~pv_q & ~reset;
    assign handshake = in_valid & in_ready;
    assign beat      = (state_q == SHIFT) & ser_ready;
    assign cnt_zero  = (cnt_q == '0);
    assign word_end  = beat & (cnt_zero | abort);

    // Next-state: word sequencing, pending slot refill and completion bookkeeping
    always_comb begin
        state_d        = state_q;
        sa_d           = sa_q;
        sb_d           = sb_q;
        cnt_d          = cnt_q;
        pa_d           = pa_q;
        pb_d           = pb_q;
        pv_d           = pv_q;
        word_done_d    = 1'b0;
        word_aborted_d = 1'b0;
        done_count_d   = done_count_q;

        case (state_q)
            IDLE: begin
                if (pv_q) begin
                    sa_d    = pa_q;
                    sb_d    = pb_q;
                    cnt_d   = CNT_TOP;
                    pv_d    = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (word_end) begin
                    word_done_d    = 1'b1;
                    word_aborted_d = abort & ~cnt_zero;
                    done_count_d   = done_count_q + CW'(1);
                    // A waiting pair starts on the very next cycle, no idle gap
                    if (pv_q) begin
                        sa_d  = pa_q;
                        sb_d  = pb_q;
                        cnt_d = CNT_TOP;
                        pv_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    sa_d  = sa_q << 1;
                    sb_d  = sb_q << 1;
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (handshake) begin
            pa_d = a_in;
            pb_d = b_in;
            pv_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sa_q           <= '0;
            sb_q           <= '0;
            cnt_q          <= '0;
            pa_q           <= '0;
            pb_q           <= '0;
            pv_q           <= 1'b0;
            word_done_q    <= 1'b0;
            word_aborted_q <= 1'b0;
            done_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            sa_q           <= sa_d;
            sb_q           <= sb_d;
            cnt_q          <= cnt_d;
            pa_q           <= pa_d;
            pb_q           <= pb_d;
            pv_q           <= pv_d;
            word_done_q    <= word_done_d;
            word_aborted_q <= word_aborted_d;
            done_count_q   <= done_count_d;
        end
    end

    assign ser_valid    = (state_q == SHIFT);
    assign ser_a        = ser_valid & sa_q[N-1];
    assign ser_b        = ser_valid & sb_q[N-1];
    assign ser_first    = ser_valid & (cnt_q == CNT_TOP);
    assign ser_last     = ser_valid & cnt_zero;
    assign word_done    = word_done_q;
    assign word_aborted = word_aborted_q;
    assign busy         = ser_valid | pv_q;
    assign done_count   = done_count_q;

endmodule
